// File: rtl/floor_request_panel_pkg.sv
// Shared constants and debouncer state encodings for the floor request panel.
package floor_request_panel_pkg;

    localparam int NUM_FLOORS_DEFAULT = 3;
    localparam int FLOOR_W            = 2;
    localparam int DB_COUNT_W         = 8;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b10,
        CHECK_LOW   = 2'b11
    } db_state_t;

endpackage

// File: rtl/floor_request_panel_if.sv
// Call-button / controller bus of the floor request panel.
interface floor_request_panel_if
    import floor_request_panel_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT
);
    logic [NUM_FLOORS-1:0] btn;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] req;
    logic [NUM_FLOORS-1:0] lamp;
    logic [FLOOR_W-1:0]    pending_count;
    logic                  press_ignored;

    modport master (
        output btn, current_floor, door_open,
        input  req, lamp, pending_count, press_ignored
    );

    modport slave (
        input  btn, current_floor, door_open,
        output req, lamp, pending_count, press_ignored
    );
endinterface

// File: rtl/floor_request_panel_button_debounce.sv
// One call button: two-flop synchronizer, four-state debouncer, press pulse on 0->1.
module button_debounce
    import floor_request_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    localparam logic [DB_COUNT_W-1:0] DB_LIMIT = DB_COUNT_W'(DEBOUNCE_CYCLES);

    logic                  sync_meta_reg;
    logic                  sync_reg;
    db_state_t             state_reg;
    logic [DB_COUNT_W-1:0] count_reg;
    logic                  press_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
            state_reg     <= STABLE_LOW;
            count_reg     <= '0;
            press_reg     <= 1'b0;
        end else begin
            sync_meta_reg <= btn_raw;
            sync_reg      <= sync_meta_reg;
            press_reg     <= 1'b0;
            // The first mismatching sample already counts as one stable cycle.
            case (state_reg)
                STABLE_LOW: begin
                    if (sync_reg) begin
                        if (DB_LIMIT == 8'd1) begin
                            state_reg <= STABLE_HIGH;
                            press_reg <= 1'b1;
                        end else begin
                            state_reg <= CHECK_HIGH;
                            count_reg <= 8'd1;
                        end
                    end
                end
                CHECK_HIGH: begin
                    if (!sync_reg) begin
                        state_reg <= STABLE_LOW;
                        count_reg <= '0;
                    end else if (count_reg + 8'd1 == DB_LIMIT) begin
                        state_reg <= STABLE_HIGH;
                        count_reg <= '0;
                        press_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_reg) begin
                        if (DB_LIMIT == 8'd1) begin
                            state_reg <= STABLE_LOW;
                        end else begin
                            state_reg <= CHECK_LOW;
                            count_reg <= 8'd1;
                        end
                    end
                end
                CHECK_LOW: begin
                    if (sync_reg) begin
                        state_reg <= STABLE_HIGH;
                        count_reg <= '0;
                    end else if (count_reg + 8'd1 == DB_LIMIT) begin
                        state_reg <= STABLE_LOW;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= STABLE_LOW;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/floor_request_panel.sv
// Latches debounced floor calls, clears the serviced floor on door_open, reports counts.
module floor_request_panel
    import floor_request_panel_pkg::*;
#(
    parameter int NUM_FLOORS      = NUM_FLOORS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 4
)(
    input  logic clk,
    input  logic reset,
    floor_request_panel_if.slave bus
);
    logic [NUM_FLOORS-1:0] press_vec;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [NUM_FLOORS-1:0] req_reg;
    logic [NUM_FLOORS-1:0] req_next;
    logic [FLOOR_W-1:0]    count_next;
    logic [FLOOR_W-1:0]    pending_count_reg;
    logic                  press_ignored_reg;
    logic                  press_ignored_next;

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .btn_raw (bus.btn[gi]),
                .press   (press_vec[gi])
            );
        end
    endgenerate

    // An out-of-range current_floor matches no bit, so nothing is cleared.
    always_comb begin
        clear_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (bus.door_open && (int'(bus.current_floor) == i)) begin
                clear_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        req_next           = (req_reg | press_vec) & ~clear_mask;
        press_ignored_next = |(press_vec & clear_mask);
        count_next         = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            count_next = count_next + FLOOR_W'(req_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_reg           <= '0;
            pending_count_reg <= '0;
            press_ignored_reg <= 1'b0;
        end else begin
            req_reg           <= req_next;
            pending_count_reg <= count_next;
            press_ignored_reg <= press_ignored_next;
        end
    end

    assign bus.req           = req_reg;
    assign bus.lamp          = req_reg;
    assign bus.pending_count = pending_count_reg;
    assign bus.press_ignored = press_ignored_reg;

endmodule

// File: tb/tb_floor_request_panel.sv
// Directed scenarios for floor_request_panel with a queue of expected observations.
module tb_floor_request_panel;
    import floor_request_panel_pkg::*;

    localparam int NF = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        string tag;
        int    kind;   // 0 req, 1 pending_count, 2 lamp, 3 press_ignored
        int    val;
    } exp_t;

    exp_t sb[$];

    floor_request_panel_if #(.NUM_FLOORS(NF)) bus ();

    floor_request_panel #(
        .NUM_FLOORS      (NF),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s value=%0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input int kind, input int val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_state(input string tag, input int req_v, input int cnt_v, input int ign_v);
        expect_val({tag, "_req"}, 0, req_v);
        expect_val({tag, "_cnt"}, 1, cnt_v);
        expect_val({tag, "_lamp"}, 2, req_v);
        expect_val({tag, "_ign"}, 3, ign_v);
    endtask

    task automatic drain();
        exp_t e;
        int   got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       got = int'(bus.req);
                1:       got = int'(bus.pending_count);
                2:       got = int'(bus.lamp);
                default: got = int'(bus.press_ignored);
            endcase
            check(e.tag, got, e.val);
        end
    endtask

    task automatic door(input int floor);
        bus.current_floor = FLOOR_W'(floor);
        bus.door_open     = 1'b1;
        tick(1);
        bus.door_open     = 1'b0;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        bus.btn           = '0;
        bus.current_floor = '0;
        bus.door_open     = 1'b0;
        tick(2);
        expect_state("rst", 0, 0, 0);
        drain();
        reset = 1'b0;

        // Single held press on floor 2: visible after edge 7, not edge 6.
        bus.btn = 3'b100;
        tick(6);
        expect_val("a_edge6_req", 0, 0);
        drain();
        tick(1);
        expect_state("a_edge7", 3'b100, 1, 0);
        drain();
        tick(3);
        bus.btn = 3'b000;
        tick(10);

        // Bouncing floor 1: one set, 7 edges after the last rising change.
        bus.btn[1] = 1'b1; tick(1);
        bus.btn[1] = 1'b0; tick(1);
        bus.btn[1] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            expect_val($sformatf("b_edge%0d_req", e), 0, 3'b100);
            drain();
        end
        tick(1);
        expect_state("b_edge7", 3'b110, 2, 0);
        drain();
        bus.btn[1] = 1'b0;
        tick(10);

        // Build req=101, then service floor 2.
        door(1);
        expect_state("c_clr1", 3'b100, 1, 0);
        drain();
        bus.btn[0] = 1'b1;
        tick(7);
        expect_state("c_set0", 3'b101, 2, 0);
        drain();
        bus.btn[0] = 1'b0;
        tick(10);
        door(2);
        expect_state("c_clr2", 3'b001, 1, 0);
        drain();

        // Press on floor 0 absorbed by the open door at floor 0.
        door(0);
        expect_state("d_clr0", 0, 0, 0);
        drain();
        bus.btn[0] = 1'b1;
        tick(6);
        bus.current_floor = 2'd0;
        bus.door_open     = 1'b1;
        tick(1);
        bus.door_open     = 1'b0;
        expect_state("d_absorb", 0, 0, 1);
        drain();
        tick(1);
        expect_state("d_after", 0, 0, 0);
        drain();
        tick(5);
        expect_val("d_held_req", 0, 0);
        drain();
        bus.btn[0] = 1'b0;
        tick(10);

        // Presses on 0 and 2 while floor 1 is being cleared.
        bus.btn[1] = 1'b1;
        tick(7);
        expect_val("e_set1_req", 0, 3'b010);
        drain();
        bus.btn[1] = 1'b0;
        tick(10);
        bus.btn = 3'b101;
        tick(6);
        bus.current_floor = 2'd1;
        bus.door_open     = 1'b1;
        tick(1);
        bus.door_open     = 1'b0;
        expect_state("e_mix", 3'b101, 2, 0);
        drain();
        bus.btn = 3'b000;
        tick(10);

        // Out-of-range floor clears nothing.
        door(3);
        expect_state("f_oob", 3'b101, 2, 0);
        drain();

        // Reset in the middle of a floor-2 debounce, button held through it.
        door(2);
        expect_val("g_clr2_req", 0, 3'b001);
        drain();
        bus.btn = 3'b100;
        tick(4);
        reset = 1'b1;
        #1;
        expect_state("g_async_rst", 0, 0, 0);
        drain();
        tick(2);
        reset = 1'b0;
        tick(6);
        expect_val("g_edge6_req", 0, 0);
        drain();
        tick(1);
        expect_state("g_edge7", 3'b100, 1, 0);
        drain();
        bus.btn = 3'b000;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/floor_request_panel.md
FLOOR_REQUEST_PANEL -- requirements
Module: floor_request_panel

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 3; number of served floors.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4; consecutive stable cycles needed to accept a button level change (legal range 1..255).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 btn  input  NUM_FLOORS  raw, asynchronous call buttons; bit i is floor i.
REQ-006 current_floor  input  2  floor the car is at, from the elevator controller.
REQ-007 door_open  input  1  controller door-open pulse; marks current_floor as serviced.
REQ-008 req  output  NUM_FLOORS  registered latched pending calls; feeds controller req.
REQ-009 lamp  output  NUM_FLOORS  button lamps; SHALL equal req.
REQ-010 pending_count  output  2  registered population count of req (0..3).
REQ-011 press_ignored  output  1  registered one-cycle pulse; a press was absorbed by an open door at that floor.

Function
REQ-012 Each btn bit SHALL pass a two-flop synchronizer before any other use.
REQ-013 Per floor, the debouncer SHALL change its debounced level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-014 A press event SHALL be a one-cycle pulse on a debounced 0->1 transition; releases generate no event.
REQ-015 Latency: btn held high, set before clock edge 1, SHALL give req[i]=1 after edge DEBOUNCE_CYCLES+3 (edge 7 at default).
REQ-016 Press event on floor i SHALL set req[i] at the next edge; a press on an already-set bit SHALL have no effect.
REQ-017 door_open=1 at an edge SHALL clear req[current_floor] at that edge.
REQ-018 Press event on floor i and clear of floor i in the same cycle: clear SHALL win, req[i]=0, press_ignored=1 on the next cycle.
REQ-019 Presses and a clear on different floors in the same cycle SHALL both take effect.
REQ-020 current_floor >= NUM_FLOORS with door_open=1 SHALL clear nothing.
REQ-021 pending_count SHALL be updated in the same edge as req and always equal popcount(req).
REQ-022 Held buttons SHALL not re-set a cleared request; a new press requires a debounced release then press.
REQ-023 Debouncer FSM per floor: states STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW; CHECK_* returns to the prior STABLE_* on mismatch, advances on count reaching DEBOUNCE_CYCLES.

Reset
REQ-024 reset SHALL force req=0, lamp=0, pending_count=0, press_ignored=0, synchronizers=0, debouncers to STABLE_LOW with count 0.
REQ-025 Reset mid-debounce SHALL discard the partial count; a button held through reset deassertion SHALL be accepted as a new press after full latency.
REQ-026 Reset deassertion SHALL be synchronous to clk externally; the block adds no reset synchronizer.

Structure
REQ-027 Shared package SHALL hold NUM_FLOORS default, floor index width (2), and debouncer state encodings (2-bit: 00,01,10,11).
REQ-028 Debouncer SHALL be a sub-module button_debounce (sync + FSM + counter + press pulse), instantiated NUM_FLOORS times via generate.
REQ-029 Request latch, clear logic, popcount and press_ignored SHALL live in the top module.

Verification
REQ-030 Reset, btn=3'b100 held 10 cycles -> req=3'b100 after edge 7, pending_count=1, lamp=3'b100.
REQ-031 btn[1] bounces 1,0,1,1 then stable high -> single set of req[1], at 7 edges after last 0->1 change; no glitch on req.
REQ-032 req=3'b101, current_floor=2, door_open=1 one cycle -> req=3'b001, pending_count=1.
REQ-033 Debounced press on floor 0 same cycle as door_open with current_floor=0 -> req[0] stays 0, press_ignored pulses once.
REQ-034 btn[0] and btn[2] pressed together while door_open clears floor 1 (req[1]=1) -> req=3'b101, pending_count=2.
REQ-035 reset asserted at cycle 4 of a btn[2] press -> req=0; btn still held after release of reset -> req[2]=1 exactly 7 edges later.
